// File: rtl/cam_frame_writer.sv
// Writes one raster-order camera frame (RGB565 byte stream) into the frame buffer.
// Armed by cap_start; waits for a full vsync pulse, stores HEIGHT lines, pulses frame_done.
module cam_frame_writer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 200,
  parameter int BPP    = 2,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cap_start,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_byte_vld,
  input  logic [7:0]        cam_byte,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              cap_busy,
  output logic              frame_done,
  output logic              frame_err
);
  localparam int LINE_BYTES = WIDTH * BPP;
  localparam int BI_W       = $clog2(LINE_BYTES + 1);
  localparam int ROW_W      = $clog2(HEIGHT + 1);
  localparam logic [BI_W-1:0]   LINE_B    = BI_W'(LINE_BYTES);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_BYTES);

  typedef enum logic [2:0] {IDLE, WAIT_VS, WAIT_FRM, CAPTURE, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              href_q, href_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]        fb_wdata_q, fb_wdata_d;
  logic              cap_busy_q, cap_busy_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic              wr_ok, line_end;

  assign wr_ok    = cam_href && cam_byte_vld && (byte_idx_q < LINE_B);
  assign line_end = href_q && !cam_href;

  always_comb begin
    state_d     = state_q;
    line_base_d = line_base_q;
    byte_idx_d  = byte_idx_q;
    row_d       = row_q;
    href_d      = cam_href;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_wdata_d  = fb_wdata_q;
    frame_err_d = frame_err_q;
    case (state_q)
      IDLE: if (cap_start) begin
        state_d     = WAIT_VS;
        frame_err_d = 1'b0;
        line_base_d = '0;
        byte_idx_d  = '0;
        row_d       = '0;
      end
      WAIT_VS:  if (cam_vsync)  state_d = WAIT_FRM;
      WAIT_FRM: if (!cam_vsync) state_d = CAPTURE;
      CAPTURE: begin
        if (wr_ok) begin
          fb_we_d    = 1'b1;
          fb_addr_d  = line_base_q + ADDR_W'(byte_idx_q);
          fb_wdata_d = cam_byte;
          byte_idx_d = byte_idx_q + BI_W'(1);
        end else if (cam_href && cam_byte_vld) begin
          frame_err_d = 1'b1;
        end
        // An href pulse that carried no bytes does not count as a line.
        if (line_end && byte_idx_q != '0) begin
          line_base_d = line_base_q + LINE_STEP;
          row_d       = row_q + ROW_W'(1);
          byte_idx_d  = '0;
          if (byte_idx_q != LINE_B) frame_err_d = 1'b1;
          if (row_q == LAST_ROW)    state_d = DONE;
        end
        if (cam_vsync && state_d != DONE) begin
          frame_err_d = 1'b1;
          fb_we_d     = 1'b0;
          state_d     = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cap_busy_d   = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      line_base_q  <= '0;
      byte_idx_q   <= '0;
      row_q        <= '0;
      href_q       <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      cap_busy_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_base_q  <= line_base_d;
      byte_idx_q   <= byte_idx_d;
      row_q        <= row_d;
      href_q       <= href_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      cap_busy_q   <= cap_busy_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign cap_busy   = cap_busy_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_cam_frame_writer.sv
// Bench for cam_frame_writer on a reduced 4x8 frame (8-byte lines) so full frames stay short.
// Expected writes come from a line/row model: row r, byte k lands at r*LINE+k.
module tb_cam_frame_writer;
  localparam int W = 4, H = 8, BPP = 2, AW = 7, LINE = W * BPP;

  logic          clk = 1'b0, reset_n = 1'b0, cap_start = 1'b0;
  logic          cam_vsync = 1'b1, cam_href = 1'b0, cam_byte_vld = 1'b0;
  logic [7:0]    cam_byte = '0;
  logic          fb_we, cap_busy, frame_done, frame_err;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_wdata;

  cam_frame_writer #(.WIDTH(W), .HEIGHT(H), .BPP(BPP), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .cap_start(cap_start), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_byte_vld(cam_byte_vld), .cam_byte(cam_byte),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .cap_busy(cap_busy),
    .frame_done(frame_done), .frame_err(frame_err));

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { string name; int mod_line; int mod_len; bit exp_err; int exp_wr; } vec_t;

  wr_t  act_q[$], exp_q[$];
  vec_t tab[5];
  int   lens[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, done_cnt = 0, done_cyc = -1, fall_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fb_we) act_q.push_back('{int'(fb_addr), int'(fb_wdata)});
    if (frame_done) begin done_cnt++; done_cyc = cyc; end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_writes(input string name);
    int bad = -1;
    n_tests++;
    if (act_q.size() != exp_q.size()) bad = 0;
    else foreach (exp_q[i]) if (bad < 0 && (act_q[i].addr != exp_q[i].addr || act_q[i].data != exp_q[i].data)) bad = i;
    if (bad >= 0) begin
      n_fail++;
      if (act_q.size() != exp_q.size())
        $display("FAIL %s writes: got %0d writes expected %0d", name, act_q.size(), exp_q.size());
      else
        $display("FAIL %s write %0d: got addr %0d data %0d expected addr %0d data %0d", name, bad,
                 act_q[bad].addr, act_q[bad].data, exp_q[bad].addr, exp_q[bad].data);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear();
    act_q.delete(); exp_q.delete(); done_cnt = 0; done_cyc = -1;
  endtask

  task automatic start_cap();
    cap_start = 1'b1; tick(); cap_start = 1'b0;
  endtask

  // One href pulse of len bytes with random gaps; rec adds the model's expected writes.
  task automatic send_line(input int len, input int row, input bit rec);
    cam_href = 1'b1; tick();
    for (int k = 0; k < len; k++) begin
      cam_byte_vld = 1'b0;
      repeat ($urandom_range(0, 1)) tick();
      cam_byte = 8'($urandom);
      cam_byte_vld = 1'b1;
      if (rec && k < LINE) exp_q.push_back('{row * LINE + k, int'(cam_byte)});
      tick();
    end
    cam_byte_vld = 1'b0; cam_href = 1'b0; fall_cyc = cyc;
    repeat ($urandom_range(2, 3)) tick();
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1; repeat (3) tick();
    cam_vsync = 1'b0; repeat (2) tick();
  endtask

  task automatic send_frame(input int ls[$]);
    int row = 0;
    vsync_pulse();
    foreach (ls[i]) begin
      send_line(ls[i], row, 1'b1);
      if (ls[i] > 0) row++;
    end
    cam_vsync = 1'b1; repeat (3) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " fb_we"}, int'(fb_we), 0);
    check({tag, " fb_addr"}, int'(fb_addr), 0);
    check({tag, " fb_wdata"}, int'(fb_wdata), 0);
    check({tag, " cap_busy"}, int'(cap_busy), 0);
    check({tag, " frame_done"}, int'(frame_done), 0);
    check({tag, " frame_err"}, int'(frame_err), 0);
  endtask

  task automatic full_lens();
    lens.delete();
    for (int r = 0; r < H; r++) lens.push_back(LINE);
  endtask

  initial begin
    tab[0] = '{"full",   -1, LINE, 1'b0, H * LINE};
    tab[1] = '{"long5",   5, 10,   1'b1, H * LINE};
    tab[2] = '{"short2",  2, 5,    1'b1, H * LINE - 3};
    tab[3] = '{"empty3",  3, 0,    1'b0, H * LINE};
    tab[4] = '{"short0",  0, 1,    1'b1, H * LINE - 7};

    #3;
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (2) tick();

    foreach (tab[i]) begin
      clear();
      start_cap();
      check({tab[i].name, " busy_armed"}, int'(cap_busy), 1);
      full_lens();
      if (tab[i].mod_len == 0) lens.insert(tab[i].mod_line, 0);
      else if (tab[i].mod_line >= 0) lens[tab[i].mod_line] = tab[i].mod_len;
      send_frame(lens);
      check({tab[i].name, " nwrites"}, act_q.size(), tab[i].exp_wr);
      check({tab[i].name, " err"}, int'(frame_err), int'(tab[i].exp_err));
      check({tab[i].name, " done_cnt"}, done_cnt, 1);
      check({tab[i].name, " busy_end"}, int'(cap_busy), 0);
      cmp_writes(tab[i].name);
      if (tab[i].mod_line < 0 && act_q.size() > 0) begin
        check("full first_addr", act_q[0].addr, 0);
        check("full last_addr", act_q[act_q.size() - 1].addr, H * LINE - 1);
      end
      if (tab[i].mod_len > LINE)
        check("long next_line_addr", (act_q.size() > (tab[i].mod_line + 1) * LINE) ?
              act_q[(tab[i].mod_line + 1) * LINE].addr : -1, (tab[i].mod_line + 1) * LINE);
    end

    // frame_done one cycle after the final line end
    clear(); start_cap(); full_lens(); send_frame(lens);
    check("done_timing", done_cyc - fall_cyc, 1);

    // cap_start mid-frame: lines before the next vsync pulse are not captured
    clear();
    cam_vsync = 1'b0;
    start_cap();
    send_line(LINE, 0, 1'b0);
    send_line(LINE, 1, 1'b0);
    check("midframe no_early_writes", act_q.size(), 0);
    full_lens(); send_frame(lens);
    check("midframe first_addr", (act_q.size() > 0) ? act_q[0].addr : -1, 0);
    check("midframe done_cnt", done_cnt, 1);
    cmp_writes("midframe");

    // vsync after 4 lines aborts
    clear(); start_cap();
    lens.delete();
    for (int r = 0; r < 4; r++) lens.push_back(LINE);
    send_frame(lens);
    check("abort err", int'(frame_err), 1);
    check("abort busy", int'(cap_busy), 0);
    check("abort done_cnt", done_cnt, 0);
    cmp_writes("abort");
    act_q.delete();
    cam_vsync = 1'b0;
    send_line(LINE, 0, 1'b0);
    check("abort idle_writes", act_q.size(), 0);

    // cap_start while busy is ignored: error from line 1 must survive
    clear(); start_cap();
    vsync_pulse();
    for (int r = 0; r < H; r++) begin
      if (r == 2) start_cap();
      send_line((r == 1) ? LINE + 2 : LINE, r, 1'b1);
    end
    cam_vsync = 1'b1; repeat (3) tick();
    check("busy_start err", int'(frame_err), 1);
    check("busy_start done_cnt", done_cnt, 1);
    cmp_writes("busy_start");

    // async reset in the middle of a line, right after a write
    clear(); start_cap();
    vsync_pulse();
    for (int r = 0; r < 3; r++) send_line(LINE, r, 1'b1);
    cam_href = 1'b1; tick();
    for (int k = 0; k < 3; k++) begin
      cam_byte = 8'($urandom_range(1, 255)); cam_byte_vld = 1'b1; tick();
    end
    check("pre_reset fb_we", int'(fb_we), 1);
    reset_n = 1'b0; #1;
    check_outputs_zero("midreset");
    cam_href = 1'b0; cam_byte_vld = 1'b0; cam_vsync = 1'b1;
    tick(); reset_n = 1'b1; tick();
    clear(); start_cap(); full_lens(); send_frame(lens);
    check("post_reset err", int'(frame_err), 0);
    check("post_reset done_cnt", done_cnt, 1);
    cmp_writes("post_reset");

    // random frames: random line lengths and occasional empty href pulses
    for (int f = 0; f < 6; f++) begin
      bit eerr = 1'b0;
      lens.delete();
      for (int r = 0; r < H; r++) begin
        int len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LINE + 3)) : LINE;
        if ($urandom_range(0, 7) == 0) lens.push_back(0);
        lens.push_back(len);
        if (len != LINE) eerr = 1'b1;
      end
      clear(); start_cap(); send_frame(lens);
      check($sformatf("rand%0d err", f), int'(frame_err), int'(eerr));
      check($sformatf("rand%0d done_cnt", f), done_cnt, 1);
      cmp_writes($sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
